// File: rtl/aemb2_wbctl.sv
// Register-file write-back controller: retires ALU results and aligned loads,
// stalls while a load waits for the data bus, and offers a one-entry forward.
module aemb2_wbctl #(
    parameter int AW = 6
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          ena_i,
    input  logic          xvld_i,
    input  logic          xwb_i,
    input  logic          xld_i,
    input  logic [1:0]    xsiz_i,
    input  logic [1:0]    xoff_i,
    input  logic          xtid_i,
    input  logic [4:0]    xrd_i,
    input  logic [31:0]   xres_i,
    input  logic [31:0]   dwb_dat_i,
    input  logic          dwb_ack_i,
    output logic [AW-1:0] rf_adr_o,
    output logic [31:0]   rf_dat_o,
    output logic          rf_wre_o,
    output logic          rf_ena_o,
    output logic          stall_o,
    input  logic [AW-1:0] fadr_i,
    output logic          fhit_o,
    output logic [31:0]   fdat_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LDW  = 2'd1,
        S_WB   = 2'd2
    } state_t;

    // Big-endian lane select with zero extension.
    function automatic logic [31:0] load_align(input logic [31:0] dat,
                                               input logic [1:0]  siz,
                                               input logic [1:0]  off);
        logic [31:0] res;
        case (siz)
            2'b00: begin
                case (off)
                    2'b00:   res = {24'h000000, dat[31:24]};
                    2'b01:   res = {24'h000000, dat[23:16]};
                    2'b10:   res = {24'h000000, dat[15:8]};
                    2'b11:   res = {24'h000000, dat[7:0]};
                    default: res = 32'h00000000;
                endcase
            end
            2'b01: begin
                if (off[1]) begin
                    res = {16'h0000, dat[15:0]};
                end else begin
                    res = {16'h0000, dat[31:16]};
                end
            end
            default: res = dat;
        endcase
        return res;
    endfunction

    state_t          state_q, state_d;
    logic            ld_tid_q, ld_tid_d;
    logic [4:0]      ld_rd_q, ld_rd_d;
    logic [1:0]      ld_siz_q, ld_siz_d;
    logic [1:0]      ld_off_q, ld_off_d;
    logic [AW-1:0]   rf_adr_q, rf_adr_d;
    logic [31:0]     rf_dat_q, rf_dat_d;
    logic            rf_wre_q, rf_wre_d;
    logic            accept_s;

    assign accept_s = ena_i & xvld_i;

    // Next-state, load bookkeeping and write-port computation.
    always_comb begin
        state_d  = state_q;
        ld_tid_d = ld_tid_q;
        ld_rd_d  = ld_rd_q;
        ld_siz_d = ld_siz_q;
        ld_off_d = ld_off_q;
        rf_adr_d = rf_adr_q;
        rf_dat_d = rf_dat_q;
        rf_wre_d = 1'b0;
        case (state_q)
            S_LDW: begin
                if (dwb_ack_i) begin
                    state_d = S_WB;
                    // A load to r0 still completes the handshake but writes nothing.
                    if (ld_rd_q != 5'd0) begin
                        rf_adr_d = AW'({ld_tid_q, ld_rd_q});
                        rf_dat_d = load_align(dwb_dat_i, ld_siz_q, ld_off_q);
                        rf_wre_d = 1'b1;
                    end else begin
                        rf_wre_d = 1'b0;
                    end
                end else begin
                    state_d = S_LDW;
                end
            end
            S_IDLE, S_WB: begin
                state_d = S_IDLE;
                if (accept_s) begin
                    if (xld_i) begin
                        state_d  = S_LDW;
                        ld_tid_d = xtid_i;
                        ld_rd_d  = xrd_i;
                        ld_siz_d = xsiz_i;
                        ld_off_d = xoff_i;
                    end else if (xwb_i && (xrd_i != 5'd0)) begin
                        rf_adr_d = AW'({xtid_i, xrd_i});
                        rf_dat_d = xres_i;
                        rf_wre_d = 1'b1;
                    end else begin
                        rf_wre_d = 1'b0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered write-port outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            ld_tid_q <= 1'b0;
            ld_rd_q  <= 5'd0;
            ld_siz_q <= 2'b00;
            ld_off_q <= 2'b00;
            rf_adr_q <= {AW{1'b0}};
            rf_dat_q <= 32'h00000000;
            rf_wre_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ld_tid_q <= ld_tid_d;
            ld_rd_q  <= ld_rd_d;
            ld_siz_q <= ld_siz_d;
            ld_off_q <= ld_off_d;
            rf_adr_q <= rf_adr_d;
            rf_dat_q <= rf_dat_d;
            rf_wre_q <= rf_wre_d;
        end
    end

    assign rf_adr_o = rf_adr_q;
    assign rf_dat_o = rf_dat_q;
    assign rf_wre_o = rf_wre_q;
    assign rf_ena_o = rf_wre_q;
    assign stall_o  = (state_q == S_LDW);
    assign fhit_o   = rf_wre_q & (fadr_i == rf_adr_q);
    assign fdat_o   = rf_dat_q;

endmodule

// File: tb/tb_aemb2_wbctl.sv
// Directed bench for aemb2_wbctl: ALU/load write-back, alignment, r0, back-to-back, reset.
module tb_aemb2_wbctl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena = 1'b0, xvld = 1'b0, xwb = 1'b0, xld = 1'b0;
    logic [1:0]  xsiz = 2'b00, xoff = 2'b00;
    logic        xtid = 1'b0;
    logic [4:0]  xrd = 5'd0;
    logic [31:0] xres = 32'h0, dwb_dat = 32'h0;
    logic        dwb_ack = 1'b0;
    logic [5:0]  rf_adr, fadr = 6'd0;
    logic [31:0] rf_dat, fdat;
    logic        rf_wre, rf_ena, stall, fhit;

    int n_pass = 0;
    int n_total = 0;

    aemb2_wbctl #(.AW(6)) dut (
        .clk_i(clk), .rst_i(rst), .ena_i(ena), .xvld_i(xvld), .xwb_i(xwb),
        .xld_i(xld), .xsiz_i(xsiz), .xoff_i(xoff), .xtid_i(xtid), .xrd_i(xrd),
        .xres_i(xres), .dwb_dat_i(dwb_dat), .dwb_ack_i(dwb_ack),
        .rf_adr_o(rf_adr), .rf_dat_o(rf_dat), .rf_wre_o(rf_wre), .rf_ena_o(rf_ena),
        .stall_o(stall), .fadr_i(fadr), .fhit_o(fhit), .fdat_o(fdat)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        ena = 1'b0; xvld = 1'b0; xwb = 1'b0; xld = 1'b0;
        xsiz = 2'b00; xoff = 2'b00; xtid = 1'b0; xrd = 5'd0; xres = 32'h0;
    endtask

    task automatic drive_instr(input logic ld, input logic wb, input logic [1:0] siz,
                               input logic [1:0] off, input logic tid, input logic [4:0] rd,
                               input logic [31:0] res);
        ena = 1'b1; xvld = 1'b1; xld = ld; xwb = wb;
        xsiz = siz; xoff = off; xtid = tid; xrd = rd; xres = res;
    endtask

    // Accepts a load, acks on the last of `waits` stall cycles, returns the WB-cycle view.
    task automatic run_load(input logic [1:0] siz, input logic [1:0] off, input logic tid,
                            input logic [4:0] rd, input logic [31:0] data, input int waits,
                            output int stalls, output logic wb_stall, output logic wre,
                            output logic [5:0] adr, output logic [31:0] dat);
        drive_instr(1'b1, 1'b0, siz, off, tid, rd, 32'hFFFFFFFF);
        @(posedge clk); #1;
        clear_inputs();
        stalls = 0;
        for (int i = 0; i < waits; i++) begin
            if (stall === 1'b1) stalls++;
            if (i == waits - 1) begin
                dwb_ack = 1'b1; dwb_dat = data;
            end
            @(posedge clk); #1;
        end
        dwb_ack = 1'b0;
        wb_stall = stall; wre = rf_wre; adr = rf_adr; dat = rf_dat;
    endtask

    task automatic test_reset();
        #1;
        n_total++; if (rf_adr !== 6'h00) $display("FAIL reset_adr: got %h expected 00", rf_adr); else n_pass++;
        n_total++; if (rf_dat !== 32'h0) $display("FAIL reset_dat: got %h expected 0", rf_dat); else n_pass++;
        n_total++; if ({rf_wre, rf_ena, stall, fhit} !== 4'b0000)
            $display("FAIL reset_ctl: got %b expected 0000", {rf_wre, rf_ena, stall, fhit}); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_alu();
        drive_instr(1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 5'd3, 32'hDEADBEEF);
        @(posedge clk); #1;
        clear_inputs();
        fadr = 6'h23; #1;
        n_total++; if (rf_adr !== 6'h23) $display("FAIL alu_adr: got %h expected 23", rf_adr); else n_pass++;
        n_total++; if (rf_dat !== 32'hDEADBEEF) $display("FAIL alu_dat: got %h expected deadbeef", rf_dat); else n_pass++;
        n_total++; if ({rf_wre, rf_ena, stall} !== 3'b110)
            $display("FAIL alu_ctl: got %b expected 110", {rf_wre, rf_ena, stall}); else n_pass++;
        n_total++; if ({fhit, fdat} !== {1'b1, 32'hDEADBEEF})
            $display("FAIL alu_fwd: got %b/%h expected 1/deadbeef", fhit, fdat); else n_pass++;
        @(posedge clk); #1;
        n_total++; if ({rf_wre, fhit} !== 2'b00) $display("FAIL alu_one_cycle: got %b expected 00", {rf_wre, fhit}); else n_pass++;
        n_total++; if (rf_dat !== 32'hDEADBEEF) $display("FAIL alu_hold: got %h expected deadbeef", rf_dat); else n_pass++;
    endtask

    task automatic test_byte_load();
        int st; logic ws, w; logic [5:0] a; logic [31:0] d;
        run_load(2'b00, 2'b10, 1'b0, 5'd7, 32'h11223344, 3, st, ws, w, a, d);
        n_total++; if (st !== 3) $display("FAIL byte_stalls: got %0d expected 3", st); else n_pass++;
        n_total++; if ({ws, w, a, d} !== {1'b0, 1'b1, 6'h07, 32'h00000033})
            $display("FAIL byte_wb: got stall=%b wre=%b adr=%h dat=%h expected 0/1/07/00000033", ws, w, a, d); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (rf_wre !== 1'b0) $display("FAIL byte_one_cycle: got %b expected 0", rf_wre); else n_pass++;
        run_load(2'b00, 2'b11, 1'b1, 5'd8, 32'h11223344, 1, st, ws, w, a, d);
        n_total++; if ({st, a, d} !== {32'd1, 6'h28, 32'h00000044})
            $display("FAIL byte_off3: got st=%0d adr=%h dat=%h expected 1/28/00000044", st, a, d); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_half_word();
        int st; logic ws, w; logic [5:0] a; logic [31:0] d;
        run_load(2'b01, 2'b00, 1'b0, 5'd9, 32'hA1B2C3D4, 2, st, ws, w, a, d);
        n_total++; if ({w, d} !== {1'b1, 32'h0000A1B2}) $display("FAIL half_off0: got %b/%h expected 1/0000a1b2", w, d); else n_pass++;
        @(posedge clk); #1;
        run_load(2'b01, 2'b11, 1'b0, 5'd10, 32'hA1B2C3D4, 2, st, ws, w, a, d);
        n_total++; if ({w, d} !== {1'b1, 32'h0000C3D4}) $display("FAIL half_off3: got %b/%h expected 1/0000c3d4", w, d); else n_pass++;
        @(posedge clk); #1;
        run_load(2'b10, 2'b01, 1'b0, 5'd11, 32'hA1B2C3D4, 2, st, ws, w, a, d);
        n_total++; if ({w, d} !== {1'b1, 32'hA1B2C3D4}) $display("FAIL word: got %b/%h expected 1/a1b2c3d4", w, d); else n_pass++;
        @(posedge clk); #1;
        run_load(2'b11, 2'b10, 1'b0, 5'd12, 32'h5A6B7C8D, 2, st, ws, w, a, d);
        n_total++; if ({w, d} !== {1'b1, 32'h5A6B7C8D}) $display("FAIL word_siz3: got %b/%h expected 1/5a6b7c8d", w, d); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_r0_idle();
        int st; logic ws, w; logic [5:0] a; logic [31:0] d;
        drive_instr(1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 5'd0, 32'h12345678);
        @(posedge clk); #1;
        clear_inputs();
        n_total++; if (rf_wre !== 1'b0) $display("FAIL r0_alu: got wre=%b expected 0", rf_wre); else n_pass++;
        run_load(2'b10, 2'b00, 1'b1, 5'd0, 32'h87654321, 4, st, ws, w, a, d);
        n_total++; if ({st, ws, w} !== {32'd4, 1'b0, 1'b0})
            $display("FAIL r0_load: got stalls=%0d stall=%b wre=%b expected 4/0/0", st, ws, w); else n_pass++;
        @(posedge clk); #1;
        dwb_ack = 1'b1; dwb_dat = 32'hCAFEF00D;
        @(posedge clk); #1;
        dwb_ack = 1'b0;
        n_total++; if ({rf_wre, stall} !== 2'b00) $display("FAIL stray_ack: got %b expected 00", {rf_wre, stall}); else n_pass++;
        @(posedge clk); #1;
        n_total++; if ({rf_wre, stall} !== 2'b00) $display("FAIL stray_ack_late: got %b expected 00", {rf_wre, stall}); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int st; logic ws, w; logic [5:0] a; logic [31:0] d;
        run_load(2'b10, 2'b00, 1'b1, 5'd5, 32'h01020304, 2, st, ws, w, a, d);
        drive_instr(1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 5'd6, 32'h0BADCAFE);
        fadr = 6'h25; #1;
        n_total++; if ({w, a, d} !== {1'b1, 6'h25, 32'h01020304})
            $display("FAIL b2b_first: got %b/%h/%h expected 1/25/01020304", w, a, d); else n_pass++;
        n_total++; if ({fhit, fdat} !== {1'b1, 32'h01020304}) $display("FAIL b2b_fwd1: got %b/%h expected 1/01020304", fhit, fdat); else n_pass++;
        fadr = 6'h05; #1;
        n_total++; if (fhit !== 1'b0) $display("FAIL b2b_nohit: got %b expected 0", fhit); else n_pass++;
        @(posedge clk); #1;
        clear_inputs();
        fadr = 6'h06; #1;
        n_total++; if ({rf_wre, rf_adr, rf_dat} !== {1'b1, 6'h06, 32'h0BADCAFE})
            $display("FAIL b2b_second: got %b/%h/%h expected 1/06/0badcafe", rf_wre, rf_adr, rf_dat); else n_pass++;
        n_total++; if ({fhit, stall} !== 2'b10) $display("FAIL b2b_fwd2: got %b expected 10", {fhit, stall}); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (rf_wre !== 1'b0) $display("FAIL b2b_end: got %b expected 0", rf_wre); else n_pass++;
    endtask

    task automatic test_reset_in_ldw();
        drive_instr(1'b1, 1'b0, 2'b10, 2'b00, 1'b1, 5'd15, 32'h0);
        @(posedge clk); #1;
        clear_inputs();
        n_total++; if (stall !== 1'b1) $display("FAIL rst_ldw_pre: got stall=%b expected 1", stall); else n_pass++;
        rst = 1'b1; #1;
        n_total++; if ({stall, rf_wre, rf_ena, rf_adr, rf_dat} !== {3'b000, 6'h00, 32'h0})
            $display("FAIL rst_ldw_vals: got %b%b%b/%h/%h expected 000/00/0", stall, rf_wre, rf_ena, rf_adr, rf_dat); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        dwb_ack = 1'b1; dwb_dat = 32'hFEEDFACE;
        @(posedge clk); #1;
        dwb_ack = 1'b0;
        n_total++; if ({rf_wre, stall, rf_dat} !== {2'b00, 32'h0})
            $display("FAIL rst_ldw_ack: got %b%b/%h expected 00/0", rf_wre, stall, rf_dat); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_byte_load();
        test_half_word();
        test_r0_idle();
        test_back_to_back();
        test_reset_in_ldw();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/aemb2_wbctl.md
# aemb2_wbctl

Write-back controller that drives the read/write port of the register-file dual-port SRAM. Accepts retiring instructions from the execute stage, either ALU results or loads, and aligns load data from the data bus. It generates registered write address, data and enable for the register file, stalls the pipeline while a load is outstanding, and exposes a one-entry forwarding compare for operand fetch.

## Interface
- AW, 6, register-file address width; address is {thread id, rd[4:0]}, so AW = 6 for two threads.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- ena_i  in  1  pipeline advance; an instruction is accepted only on a cycle with ena_i=1.
- xvld_i  in  1  a valid instruction is present at write-back input.
- xwb_i  in  1  instruction writes rd (ALU path).
- xld_i  in  1  instruction is a load; overrides xwb_i.
- xsiz_i  in  2  load size: 00 byte, 01 half, 10 word, 11 treated as word.
- xoff_i  in  2  load byte address bits [1:0].
- xtid_i  in  1  thread id.
- xrd_i  in  5  destination register.
- xres_i  in  32  ALU result.
- dwb_dat_i  in  32  data-bus read data.
- dwb_ack_i  in  1  data-bus acknowledge; one-cycle pulse.
- rf_adr_o  out  AW  register-file write address, {tid, rd}.
- rf_dat_o  out  32  register-file write data.
- rf_wre_o  out  1  register-file write enable.
- rf_ena_o  out  1  register-file port enable; equal to rf_wre_o.
- stall_o  out  1  pipeline must hold; combinational from state.
- fadr_i  in  AW  operand-fetch address to compare.
- fhit_o  out  1  fadr_i matches the write in progress.
- fdat_o  out  32  forwarded data; equals rf_dat_o.

## Operation
- States:
  - IDLE: accepts instructions, stall_o=0.
  - LDW: load waiting for ack, stall_o=1.
  - WB: load data writes, stall_o=0.
- IDLE, accept cycle ena_i & xvld_i:
  - If xld_i: latch tid, rd, siz and off, then go to LDW.
  - Else if xwb_i: next cycle rf_adr_o={xtid_i,xrd_i}, rf_dat_o=xres_i, rf_wre_o=1. State stays IDLE.
  - Else: no write.
- LDW:
  - ena_i, xvld_i and all x* inputs are ignored.
  - On dwb_ack_i: the aligned data is registered into rf_dat_o, rf_adr_o is set to the latched address, and the state goes to WB.
- WB:
  - rf_wre_o=1 for exactly this cycle.
  - The accept rules of IDLE apply to the cycle's inputs, so a back-to-back instruction is accepted with no bubble.
  - Next state is IDLE, or LDW if the accepted instruction is a load.
- In every other cycle rf_wre_o=0. rf_adr_o and rf_dat_o hold their last values.
- r0 suppression: when the rd field is 0, rf_wre_o stays 0 for both ALU and load. A load to r0 still waits for ack.
- Load alignment is big-endian with zero-extension:
  - byte: off 00 gives [31:24], 01 gives [23:16], 10 gives [15:8], 11 gives [7:0], each zero-extended.
  - half: off[1]=0 gives [31:16], 1 gives [15:0]; off[0] is ignored.
  - word: dwb_dat_i unchanged.
- Forwarding: fhit_o = rf_wre_o & (fadr_i == rf_adr_o). fdat_o = rf_dat_o.

## Timing
- Reset values: state IDLE; rf_adr_o=0, rf_dat_o=0, rf_wre_o=0, rf_ena_o=0; stall_o=0, fhit_o=0.
- ALU latency: accept at edge N, write visible in cycle N+1.
- Load latency: accept at edge N; stall_o=1 from cycle N+1 until the ack edge A. Write occurs in cycle A+1 with stall_o=0.
- An ack in the same cycle the load enters LDW is not possible, because LDW is entered at edge N. The earliest ack is sampled at edge N+1.
- dwb_ack_i in IDLE or WB is ignored.
- Reset mid-load: the FSM returns to IDLE immediately. A later ack is ignored and no write is produced.

## Test plan
- ALU write: accept xtid=1, xrd=3, xres=0xDEADBEEF → next cycle rf_adr_o=0x23, rf_dat_o=0xDEADBEEF, rf_wre_o=1 for one cycle.
- Byte load: xsiz=00, xoff=10, ack after 3 cycles with dwb_dat_i=0x11223344 → stall_o=1 for 3 cycles, then write of 0x00000033.
- Half and word loads: dwb_dat_i=0xA1B2C3D4.
  - half, off 00 → 0x0000A1B2.
  - half, off 11 → 0x0000C3D4.
  - word → 0xA1B2C3D4.
- r0 and idle: ALU write and load to rd=0 → rf_wre_o never asserted, load still stalls until ack. A stray ack in IDLE → no write.
- Back-to-back: load acked, then an ALU instruction accepted in the WB cycle → two consecutive write cycles with correct addresses. fhit_o=1 when fadr_i equals each address.
- Reset asserted in LDW → outputs return to reset values. A subsequent ack produces no write.
